riscv_core_divider: RTL

Iterative radix-2 integer divider for the M-extension execute stage of the RV32IMC 5-stage pipeline. Computes DIV, DIVU, REM and REMU using a restoring shift-subtract loop over XLEN cycles, with single-cycle fast paths for the architecturally defined corner cases. Sits beside the ALU and adder/multiplier in EX. Uses a valid/ready handshake so the hazard unit can stall the pipeline while the divider is busy.

---
 rtl/riscv_core_pkg.sv | 40 ++++
 rtl/riscv_core_divider_if.sv | 32 +++
 rtl/riscv_core_div_step.sv | 26 ++
 rtl/riscv_core_divider.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/riscv_core_pkg.sv
// Shared core definitions for the M-extension divider: operation and FSM
// encodings, widths and small helpers used by both RTL and bench.
package riscv_core_pkg;

   localparam int XLEN      = 32;
   localparam int DIV_CNT_W = $clog2(XLEN);

   // Most negative signed value; dividend half of the signed-overflow case.
   localparam logic [XLEN-1:0] DIV_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   // Encoding follows funct3[1:0] of the M-extension divide instructions.
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FIXUP = 2'b10,
      DONE  = 2'b11
   } div_state_e;

   function automatic logic op_is_signed(input div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

   // Two's complement negation when neg is set, pass-through otherwise.
   function automatic logic [XLEN-1:0] negate_if(input logic neg,
                                                 input logic [XLEN-1:0] v);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/riscv_core_divider_if.sv
// Request/result bundle between the EX stage and the divider.
// Handshake: a request transfers on a rising edge where i_div_valid and
// o_div_ready are both high and i_div_flush is low; a result transfers on a
// rising edge where o_div_result_valid and i_div_result_ready are both high.
// A valid is never withdrawn by the divider until its transfer (or a flush).
interface riscv_core_divider_if;

   logic                             i_div_valid;
   logic                             o_div_ready;
   logic [1:0]                       i_div_op;
   logic [riscv_core_pkg::XLEN-1:0]  i_div_srcA;
   logic [riscv_core_pkg::XLEN-1:0]  i_div_srcB;
   logic                             i_div_flush;
   logic                             o_div_result_valid;
   logic                             i_div_result_ready;
   logic [riscv_core_pkg::XLEN-1:0]  o_div_result;

   // Divider side.
   modport slave (
      input  i_div_valid, i_div_op, i_div_srcA, i_div_srcB, i_div_flush,
             i_div_result_ready,
      output o_div_ready, o_div_result_valid, o_div_result
   );

   // Pipeline / requester side.
   modport master (
      output i_div_valid, i_div_op, i_div_srcA, i_div_srcB, i_div_flush,
             i_div_result_ready,
      input  o_div_ready, o_div_result_valid, o_div_result
   );

endinterface

// File: rtl/riscv_core_div_step.sv
// One restoring shift-subtract iteration. Purely combinational so that two
// copies can later be chained for a radix-4 (2 bits per cycle) variant.
module riscv_core_div_step
   import riscv_core_pkg::*;
(
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_rem,
   output logic [XLEN-1:0] o_quo
);

   // Shifted remainder keeps the bit falling out of R: for DIVU the divisor
   // can approach 2^XLEN, so 2R+1 may need XLEN+1 bits.
   logic [XLEN:0] rem_sh;
   logic [XLEN:0] trial;

   // Trial subtraction decides the next quotient bit and remainder.
   always_comb begin
      rem_sh = {i_rem, i_quo[XLEN-1]};
      trial  = rem_sh - {1'b0, i_divisor};
      o_rem  = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
      o_quo  = {i_quo[XLEN-2:0], ~trial[XLEN]};
   end

endmodule

// File: rtl/riscv_core_divider.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU. Corner cases (divide by
// zero, signed overflow) finish in one cycle; everything else runs XLEN
// restoring iterations on magnitudes, then a sign fixup cycle.
module riscv_core_divider
   import riscv_core_pkg::*;
(
   input  logic                        i_clk,
   input  logic                        i_rst,
   riscv_core_divider_if.slave         div_if,
   output div_state_e                  o_dbg_state
);

   localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(XLEN - 1);
   localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);

   div_state_e             state_q, state_d;
   div_op_e                op_q, op_d;
   logic                   quo_neg_q, quo_neg_d;
   logic                   rem_neg_q, rem_neg_d;
   logic [XLEN-1:0]        rem_q, rem_d;
   logic [XLEN-1:0]        quo_q, quo_d;
   logic [XLEN-1:0]        dvsr_q, dvsr_d;
   logic [XLEN-1:0]        result_q, result_d;
   logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;

   // Request decode, only meaningful in the accept cycle.
   div_op_e                in_op;
   logic                   in_signed;
   logic                   sign_a, sign_b;
   logic [XLEN-1:0]        abs_a, abs_b;
   logic                   div_zero, sgn_ovf, accept;

   logic [XLEN-1:0]        step_rem, step_quo;
   logic [XLEN-1:0]        fin_quo, fin_rem;

   assign in_op     = div_op_e'(div_if.i_div_op);
   assign in_signed = op_is_signed(in_op);
   assign sign_a    = in_signed & div_if.i_div_srcA[XLEN-1];
   assign sign_b    = in_signed & div_if.i_div_srcB[XLEN-1];
   assign abs_a     = negate_if(sign_a, div_if.i_div_srcA);
   assign abs_b     = negate_if(sign_b, div_if.i_div_srcB);
   assign div_zero  = (div_if.i_div_srcB == '0);
   assign sgn_ovf   = in_signed && (div_if.i_div_srcA == DIV_INT_MIN)
                      && (div_if.i_div_srcB == '1);
   assign accept    = div_if.i_div_valid && (state_q == IDLE)
                      && !div_if.i_div_flush;

   // Sign flags are only ever set for signed ops, so unsigned ops pass through.
   assign fin_quo   = negate_if(quo_neg_q, quo_q);
   assign fin_rem   = negate_if(rem_neg_q, rem_q);

   riscv_core_div_step u_step (
      .i_rem     (rem_q),
      .i_quo     (quo_q),
      .i_divisor (dvsr_q),
      .o_rem     (step_rem),
      .o_quo     (step_quo)
   );

   // Next-state and datapath selection; flush has the final word.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      result_d  = result_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = in_op;
               quo_neg_d = sign_a ^ sign_b;
               rem_neg_d = sign_a;
               if (div_zero) begin
                  result_d = op_is_rem(in_op) ? div_if.i_div_srcA : '1;
                  state_d  = DONE;
               end else if (sgn_ovf) begin
                  result_d = op_is_rem(in_op) ? '0 : DIV_INT_MIN;
                  state_d  = DONE;
               end else begin
                  rem_d   = '0;
                  quo_d   = abs_a;
                  dvsr_d  = abs_b;
                  cnt_d   = CNT_LAST;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
               state_d = FIXUP;
            end
         end
         FIXUP: begin
            result_d = op_is_rem(op_q) ? fin_rem : fin_quo;
            state_d  = DONE;
         end
         DONE: begin
            if (div_if.i_div_result_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (div_if.i_div_flush) begin
         state_d = IDLE;
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         op_q      <= DIV;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         quo_neg_q <= quo_neg_d;
         rem_neg_q <= rem_neg_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         result_q  <= result_d;
         cnt_q     <= cnt_d;
      end
   end

   assign div_if.o_div_ready        = (state_q == IDLE);
   assign div_if.o_div_result_valid = (state_q == DONE);
   assign div_if.o_div_result       = result_q;
   assign o_dbg_state               = state_q;

endmodule
